// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin sharing of a show-ahead FIFO read port among NUM_REQ consumers in bursts of BURST_LEN words.
// Define FIFO_RD_ARB_HOLD_EN to let a lone requester keep its grant across bursts without an idle cycle.
module fifo_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATASIZE  = 8,
  parameter int BURST_LEN = 4,
  parameter int BCNT_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [NUM_REQ-1:0]  i_ready,
  input  logic                i_empty,
  input  logic [DATASIZE-1:0] i_rd_data,
  output logic                o_rd_en,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [NUM_REQ-1:0]  o_valid,
  output logic [DATASIZE-1:0] o_rd_data,
  output logic                o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, valid_q, valid_d;
  logic [DATASIZE-1:0] data_q, data_d;
  logic [IW-1:0]       ptr_q, ptr_d, g_q, g_d, pick, idx;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                hold;
  // Scan downward so the last hit, i.e. the first set bit at or after ptr_q, wins.
  always_comb begin
    pick = ptr_q;
    idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (i_req[idx]) pick = idx;
    end
  end
`ifdef FIFO_RD_ARB_HOLD_EN
  assign hold = bcnt_q == BCNT_W'(BURST_LEN) && i_req[g_q] && !(|(i_req & ~grant_q));
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    bcnt_d  = bcnt_q;
    o_rd_en = 1'b0;
    case (state_q)
      IDLE: if (|i_req) begin
        g_d     = pick;
        grant_d = NUM_REQ'(1) << pick;
        bcnt_d  = '0;
        state_d = GRANT;
      end
      GRANT: begin
        o_rd_en = !i_empty && i_req[g_q] && bcnt_q < BCNT_W'(BURST_LEN) && (!valid_q[g_q] || i_ready[g_q]);
        if (o_rd_en) begin
          data_d  = i_rd_data;
          valid_d = grant_q;
          bcnt_d  = bcnt_q + BCNT_W'(1);
        end else if (valid_q[g_q] && i_ready[g_q]) valid_d = '0;
        if (bcnt_d == BCNT_W'(BURST_LEN) || !i_req[g_q]) state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q[g_q] && i_ready[g_q]) valid_d = '0;
        if (hold) begin
          bcnt_d  = '0;
          state_d = GRANT;
        end else if (!valid_q[g_q]) begin
          grant_d = '0;
          ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      g_q     <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      bcnt_q  <= bcnt_d;
    end
  end
  assign o_grant   = grant_q;
  assign o_valid   = valid_q;
  assign o_rd_data = data_q;
  assign o_busy    = state_q != IDLE;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: scoreboard bench; each word pushed into the FIFO model carries the consumer the arbitration rules say must receive it.
module tb_fifo_rd_arbiter;
  localparam int N = 4, W = 8, BL = 4;
  logic         i_clk = 1'b0, i_rst_n = 1'b1, i_empty = 1'b1, o_rd_en, o_busy;
  logic [N-1:0] i_req = '0, i_ready = '0, o_grant, o_valid;
  logic [W-1:0] i_rd_data = '0, o_rd_data;
  typedef struct {int c; logic [W-1:0] d;} exp_t;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] fifo[$];
  int           checks = 0, fails = 0, idle_cnt = 0;
  bit           pop_now;

  fifo_rd_arbiter #(.NUM_REQ(N), .DATASIZE(W), .BURST_LEN(BL), .BCNT_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_ready(i_ready),
    .i_empty(i_empty), .i_rd_data(i_rd_data), .o_rd_en(o_rd_en),
    .o_grant(o_grant), .o_valid(o_valid), .o_rd_data(o_rd_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    i_empty   = fifo.size() == 0;
    i_rd_data = i_empty ? '0 : fifo[0];
  endtask

  task automatic push(logic [W-1:0] d, int c);
    fifo.push_back(d);
    exp_q.push_back('{c: c, d: d});
    refresh();
  endtask

  // Pop decision is taken at the negedge, the FIFO moves 1 ns after the rising edge.
  task automatic tick();
    @(negedge i_clk);
    pop_now = o_rd_en;
    if (!o_busy) idle_cnt++;
    @(posedge i_clk);
    #1;
    if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req   = '0;
    i_ready = '0;
    fifo.delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic wait_drain(string name, int budget);
    for (int b = 0; b < budget && exp_q.size() > 0; b++) tick();
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge i_clk) if (i_rst_n) begin
    check("rd_en_while_empty", 32'(o_rd_en && i_empty), 32'd0);
    check("valid_subset_grant", 32'(o_valid & ~o_grant), 32'd0);
    check("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
    for (int i = 0; i < N; i++) if (o_valid[i] && i_ready[i]) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_word: consumer %0d got %0h, nothing expected", i, o_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_consumer", 32'(i), 32'(mon_e.c));
        check("word_data", 32'(o_rd_data), 32'(mon_e.d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    refresh();
    do_reset();
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_rd_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_rd_en", 32'(o_rd_en), 32'd0);
    // Single consumer, three words, then the FIFO runs dry while the grant holds.
    push(8'h11, 2);
    push(8'h22, 2);
    push(8'h33, 2);
    i_req   = 4'b0100;
    i_ready = '1;
    tick();
    check("p1_grant_edge1", 32'(o_grant), 32'h4);
    tick();
    check("p1_valid_edge2", 32'(o_valid), 32'h4);
    check("p1_data_edge2", 32'(o_rd_data), 32'h11);
    wait_drain("p1", 20);
    tick();
    check("p1_no_pop_when_empty", 32'(o_rd_en), 32'd0);
    check("p1_grant_held", 32'(o_grant), 32'h4);
    // Consumer stalls on the first word.
    do_reset();
    i_req = 4'b0001;
    push(8'hA5, 0);
    push(8'h5A, 0);
    tick();
    tick();
    check("p2_valid", 32'(o_valid), 32'h1);
    check("p2_data", 32'(o_rd_data), 32'hA5);
    tick();
    tick();
    check("p2_stall_data", 32'(o_rd_data), 32'hA5);
    check("p2_stall_rd_en", 32'(o_rd_en), 32'd0);
    i_ready = 4'b0001;
    #1;
    check("p2_resume_rd_en", 32'(o_rd_en), 32'd1);
    wait_drain("p2", 20);
    // Request drops with an unaccepted word: grant held through the drain.
    do_reset();
    i_req = 4'b0010;
    push(8'h77, 1);
    tick();
    tick();
    check("p3_valid", 32'(o_valid), 32'h2);
    i_req = '0;
    tick();
    check("p3_drain_grant", 32'(o_grant), 32'h2);
    check("p3_drain_busy", 32'(o_busy), 32'd1);
    tick();
    check("p3_drain_hold", 32'(o_grant), 32'h2);
    i_req   = '1;
    i_ready = '1;
    tick();
    check("p3_grant_after_accept", 32'(o_grant), 32'h2);
    tick();
    check("p3_grant_cleared", 32'(o_grant), 32'd0);
    check("p3_idle", 32'(o_busy), 32'd0);
    tick();
    check("p3_next_rr", 32'(o_grant), 32'h4);
    check("p3_exp_empty", 32'(exp_q.size()), 32'd0);
    // Lone requester over 12 words.
    do_reset();
    i_req   = 4'b0010;
    i_ready = '1;
    for (int k = 0; k < 12; k++) push(8'(8'h40 + k), 1);
    tick();
    idle_cnt = 0;
    wait_drain("p4", 200);
`ifdef FIFO_RD_ARB_HOLD_EN
    check("p4_idle_cycles", 32'(idle_cnt), 32'd0);
`else
    check("p4_idle_cycles", 32'(idle_cnt), 32'(12 / BL - 1));
`endif
    // Asynchronous reset in the middle of a grant.
    do_reset();
    i_req = 4'b0001;
    push(8'hC3, 0);
    tick();
    tick();
    check("p5_valid_before_rst", 32'(o_valid), 32'h1);
    i_rst_n = 1'b0;
    #2;
    check("p5_async_grant", 32'(o_grant), 32'd0);
    check("p5_async_valid", 32'(o_valid), 32'd0);
    check("p5_async_busy", 32'(o_busy), 32'd0);
    check("p5_async_data", 32'(o_rd_data), 32'd0);
    do_reset();
    // Everyone requests: word k belongs to consumer (k / BL) mod N.
    i_req = '1;
    n = 0;
    for (int b = 0; b < 4000 && (n < 64 || exp_q.size() > 0); b++) begin
      i_ready = 4'($urandom);
      if (n < 64 && $urandom_range(0, 1) == 1) begin
        push(8'($urandom), (n / BL) % N);
        n++;
      end
      tick();
    end
    check("p6_words_pushed", 32'(n), 32'd64);
    check("p6_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
